up_sampler_2_2: RTL and testbench
=================================

// Module: up_sampler_2_2
// PURPOSE
//  Interpolating up-sampler by L. It is the transmit-side counterpart of the 2:2 down-sampler.
//  It accepts one signed sample per L output slots from the upstream filter through a
//  valid/ready handshake. It emits each sample on phase 0 of the output-rate clk_en and
//  fills the other L-1 slots with zeros. It sits between the pulse-shaping filter and the DAC path.
// PARAMETERS
//  WIDTH  18            sample width, signed two's complement
//  L      4             interpolation factor; legal range 2..16
//  CNT_W  $clog2(L)     phase counter width (derived; do not override)
// PORTS
//  clk        in   1      system clock; all state on rising edge
//  reset      in   1      asynchronous, active-high reset
//  clk_en     in   1      output-rate strobe, 1 cycle wide; one output slot per strobe
//  in_valid   in   1      upstream sample valid
//  x_in       in   WIDTH  upstream sample (signed)
//  in_ready   out  1      single-entry buffer empty; equals !buf_full (registered, no comb path)
//  y          out  WIDTH  up-sampled output (signed, registered)
//  y_valid    out  1      high for 1 cycle, the cycle after each clk_en
//  phase      out  CNT_W  current output slot index 0..L-1
//  overrun    out  1      sticky: sample offered while buffer full (sample dropped)
//  underrun   out  1      sticky: phase-0 slot reached with buffer empty
//  clr_flags  in   1      synchronous clear of overrun/underrun
// BEHAVIOUR
//  - Reset (async assert, sync release): phase=0, buf=0, buf_full=0, y=0, y_valid=0,
//    overrun=0, underrun=0. A reset mid-frame discards the buffered sample and the phase.
//  - Accept: when in_valid && in_ready, buf<=x_in and buf_full<=1 on that edge.
//  - Reject: when in_valid && !in_ready, overrun<=1. The sample is dropped and buf is unchanged.
//  - Slot on clk_en:
//      phase <= (phase==L-1) ? 0 : phase+1  (wrap at L-1)
//      phase==0 && buf_full : y<=buf, buf_full<=0
//      phase==0 && !buf_full: y<=0, underrun<=1
//      phase!=0             : y<=0 (zero stuffing)
//  - y_valid<=clk_en. Latency from clk_en to y/y_valid is 1 cycle. y holds between strobes.
//  - Simultaneous events, with phase==0 && clk_en in the same cycle:
//      buffer full + in_valid: consumption happens; new sample rejected, overrun set
//        (in_ready was already low, no bypass).
//      buffer empty + in_valid: underrun set, y=0; sample written, buf_full=1 for next frame.
//  - clr_flags clears both flags. A set event in the same cycle wins (flag stays 1).
//  - clk_en held low: phase, y and buffer are frozen; handshake accept still operates.
//  - No gain compensation: the zero-stuffed stream has DC gain 1/L. The downstream filter owns the xL.
// CONFIGURATION
//  UPSAMPLE_HOLD_EN defined: zero-order hold. On phase!=0, y keeps the last phase-0 value
//    instead of 0. On underrun, y also holds its previous value instead of 0; underrun still sets.
//  UPSAMPLE_HOLD_EN undefined (default): zero stuffing as specified above.
// TESTING
//  1 Reset: drive in_valid=1 with reset=1 for 5 cycles -> all outputs 0, in_ready=1, phase=0.
//  2 Steady stream, L=4, clk_en every 3rd cycle: feed 100, -200, 131071 one per frame
//    -> y sequence 100,0,0,0,-200,0,0,0,131071,0,0,0; y_valid 1 cycle after each clk_en;
//    no flags set.
//  3 Overrun: accept 55, then assert in_valid with 77 before the next phase 0
//    -> overrun=1, y at phase 0 = 55, 77 never appears; clr_flags -> overrun=0.
//  4 Underrun: no input for one frame -> y=0 at phase 0, underrun=1. Then supply
//    -131072 -> it appears at the next phase 0.
//  5 Simultaneous: in_valid with 9 arrives with buffer empty in the same cycle as phase-0 clk_en
//    -> underrun=1, y=0, and 9 emerges one frame later. With buffer full (holding 4) -> y=4,
//    overrun=1, and 9 is lost.
//  6 Reset mid-frame at phase=2 with buffer full -> phase=0, in_ready=1, y=0 asynchronously.
//    Rerun test 2 with UPSAMPLE_HOLD_EN -> y 100,100,100,100,-200,...

Source files
------------

// File: rtl/up_sampler_2_2_if.sv
// up_sampler_2_2_if: sample handshake, output-slot strobe and status bundle for the up-sampler.
// Latency: none (wires only).
// Backpressure: in_ready is driven by the up-sampler's registered buffer state.
interface up_sampler_2_2_if #(
  parameter int WIDTH = 18,
  parameter int L     = 4
);
  localparam int CNT_W = $clog2(L);

  // output-rate slot strobe and flag clear from the DAC-side control
  logic                     clk_en;
  logic                     clr_flags;

  // upstream sample handshake
  logic                     in_valid;
  logic signed [WIDTH-1:0]  x_in;
  logic                     in_ready;

  // up-sampled stream and status
  logic signed [WIDTH-1:0]  y;
  logic                     y_valid;
  logic        [CNT_W-1:0]  phase;
  logic                     overrun;
  logic                     underrun;

  // driven by the upstream filter / control side
  modport master (
    output clk_en, clr_flags, in_valid, x_in,
    input  in_ready, y, y_valid, phase, overrun, underrun
  );

  // the up-sampler itself
  modport slave (
    input  clk_en, clr_flags, in_valid, x_in,
    output in_ready, y, y_valid, phase, overrun, underrun
  );
endinterface

// File: rtl/up_sampler_2_2.sv
// up_sampler_2_2: interpolate by L; sample on phase 0, zeros on other slots (UPSAMPLE_HOLD_EN: zero-order hold).
// Latency: y/y_valid one cycle after clk_en; an accepted sample leaves at the next phase-0 slot.
// Backpressure: single-entry buffer, in_ready = !buf_full (registered); offers while full are dropped and set overrun.
module up_sampler_2_2 #(
  parameter int WIDTH = 18,
  parameter int L     = 4
) (
  input  logic            clk,
  input  logic            reset,
  up_sampler_2_2_if.slave bus
);

  localparam int               CNT_W   = $clog2(L);
  localparam logic [CNT_W-1:0] PH_LAST = CNT_W'(L - 1);

`ifdef UPSAMPLE_HOLD_EN
  // non-sample slots and underrun slots repeat the previous output
  localparam bit HOLD_EN = 1'b1;
`else
  // non-sample slots and underrun slots emit zero
  localparam bit HOLD_EN = 1'b0;
`endif

  // interpolation factor outside 2..16 is not supported
  if (L < 2 || L > 16) begin : g_bad_l
    $error("up_sampler_2_2: L must be in 2..16");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic        [CNT_W-1:0] phase_q,    phase_d;
  logic signed [WIDTH-1:0] buf_q,      buf_d;
  logic                    buf_full_q, buf_full_d;
  logic signed [WIDTH-1:0] y_q,        y_d;
  logic                    y_valid_q,  y_valid_d;
  logic                    overrun_q,  overrun_d;
  logic                    underrun_q, underrun_d;

  // ---------------------------------------------------------------------------
  // Events of this cycle, all decoded from registered state (no bypass paths)
  // ---------------------------------------------------------------------------
  logic slot0;     // strobe lands on the sample slot
  logic accept;    // handshake completes, buffer captures x_in
  logic consume;   // sample slot with a buffered sample
  logic ovr_set;   // sample offered while the buffer is occupied
  logic und_set;   // sample slot reached with nothing buffered

  assign slot0   = bus.clk_en && (phase_q == '0);
  assign accept  = bus.in_valid && !buf_full_q;
  assign consume = slot0 && buf_full_q;
  assign ovr_set = bus.in_valid && buf_full_q;
  assign und_set = slot0 && !buf_full_q;

  // Phase counter advances one slot per strobe and wraps after L-1.
  always_comb begin
    phase_d = phase_q;
    if (bus.clk_en) begin
      if (phase_q == PH_LAST) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + CNT_W'(1);
      end
    end
  end

  // Single-entry buffer: accept and consume are mutually exclusive because
  // accept needs it empty and consume needs it full, so a sample offered on
  // the consuming slot is rejected rather than passed through.
  always_comb begin
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    if (accept) begin
      buf_d      = bus.x_in;
      buf_full_d = 1'b1;
    end else if (consume) begin
      buf_full_d = 1'b0;
    end
  end

  // Output slot: the buffered sample on phase 0, otherwise zero (or hold).
  // y only changes on a strobe, so it holds between strobes.
  always_comb begin
    y_d       = y_q;
    y_valid_d = bus.clk_en;
    if (bus.clk_en) begin
      if (consume) begin
        y_d = buf_q;
      end else if (!HOLD_EN) begin
        y_d = '0;
      end
    end
  end

  // Sticky flags: a set event in the same cycle as clr_flags wins.
  always_comb begin
    overrun_d  = ovr_set || (overrun_q  && !bus.clr_flags);
    underrun_d = und_set || (underrun_q && !bus.clr_flags);
  end

  // State register; reset also discards any buffered sample and the phase.
  // Reset release is expected to be synchronised to clk by the reset tree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      y_q        <= '0;
      y_valid_q  <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      y_q        <= y_d;
      y_valid_q  <= y_valid_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, all straight from flops
  // ---------------------------------------------------------------------------
  assign bus.in_ready = !buf_full_q;
  assign bus.y        = y_q;
  assign bus.y_valid  = y_valid_q;
  assign bus.phase    = phase_q;
  assign bus.overrun  = overrun_q;
  assign bus.underrun = underrun_q;

endmodule

// File: tb/tb_up_sampler_2_2.sv
// tb_up_sampler_2_2: directed scenarios plus random traffic against a slot-count/queue reference model.
// Latency: checks every cycle on the falling edge, one edge after the stimulus.
// Backpressure: the model tracks the single-entry buffer as a queue of depth one.
`timescale 1ns/1ps
module tb_up_sampler_2_2;
  localparam int WIDTH = 18;
  localparam int L     = 4;
`ifdef UPSAMPLE_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  up_sampler_2_2_if #(.WIDTH(WIDTH), .L(L)) bus ();
  up_sampler_2_2 #(.WIDTH(WIDTH), .L(L)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: buffered samples, strobe count, expected registered outputs
  int mq[$];
  int m_slots;
  int m_y;
  bit m_yv, m_ovr, m_und;

  int cap[$];
  bit capturing = 1'b0;
  int s2[3] = '{100, -200, 131071};

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_slots = 0;
    m_y     = 0;
    m_yv    = 1'b0;
    m_ovr   = 1'b0;
    m_und   = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".y"},        $signed(bus.y), m_y);
    chk({tag, ".y_valid"},  bus.y_valid,    m_yv);
    chk({tag, ".phase"},    bus.phase,      m_slots % L);
    chk({tag, ".in_ready"}, bus.in_ready,   mq.size() == 0);
    chk({tag, ".overrun"},  bus.overrun,    m_ovr);
    chk({tag, ".underrun"}, bus.underrun,   m_und);
  endtask

  // Drive one cycle of inputs (called at a falling edge), advance the model
  // through the next rising edge, then compare at the following falling edge.
  task automatic step(input bit ce, input bit iv, input int x, input bit clr);
    bit full_pre, os, us;
    bus.clk_en    = ce;
    bus.in_valid  = iv;
    bus.x_in      = WIDTH'(x);
    bus.clr_flags = clr;
    full_pre = (mq.size() != 0);
    os = 1'b0;
    us = 1'b0;
    if (ce) begin
      if (m_slots % L == 0) begin
        if (full_pre) m_y = mq.pop_front();
        else begin
          us = 1'b1;
          if (!HOLD) m_y = 0;
        end
      end else if (!HOLD) begin
        m_y = 0;
      end
      m_slots++;
    end
    if (iv) begin
      if (full_pre) os = 1'b1;
      else mq.push_back(x);
    end
    m_ovr = os || (m_ovr && !clr);
    m_und = us || (m_und && !clr);
    m_yv  = ce;
    @(negedge clk);
    if (capturing && bus.y_valid) cap.push_back(int'($signed(bus.y)));
    check_all("step");
  endtask

  // n output slots with clk_en every other cycle
  task automatic slots(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 0, 1'b0);
      step(1'b1, 1'b0, 0, 1'b0);
    end
  endtask

  function automatic int rnd_sample();
    logic signed [WIDTH-1:0] v;
    v = WIDTH'($urandom);
    return int'(v);
  endfunction

  initial begin
    // 1: reset held with in_valid asserted
    bus.clk_en    = 1'b0;
    bus.in_valid  = 1'b1;
    bus.x_in      = '0;
    bus.clr_flags = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      bus.x_in = WIDTH'($urandom);
      @(negedge clk);
    end
    chk("rst.y",        $signed(bus.y), 0);
    chk("rst.y_valid",  bus.y_valid,    0);
    chk("rst.phase",    bus.phase,      0);
    chk("rst.in_ready", bus.in_ready,   1);
    chk("rst.overrun",  bus.overrun,    0);
    chk("rst.underrun", bus.underrun,   0);
    bus.in_valid = 1'b0;
    reset = 1'b0;

    // 2: steady stream, clk_en every 3rd cycle, one sample per frame
    capturing = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int s = 0; s < L; s++) begin
        step(1'b0, s == 0, s2[f], 1'b0);
        step(1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 1'b0);
      end
    end
    capturing = 1'b0;
    chk("t2.count", cap.size(), 3 * L);
    for (int k = 0; k < cap.size() && k < 3 * L; k++) begin
      chk("t2.seq", cap[k], (k % L == 0 || HOLD) ? s2[k / L] : 0);
    end
    chk("t2.overrun",  bus.overrun,  0);
    chk("t2.underrun", bus.underrun, 0);

    // 3: overrun, second sample dropped
    step(1'b0, 1'b1, 55, 1'b0);
    step(1'b0, 1'b1, 77, 1'b0);
    chk("t3.overrun", bus.overrun, 1);
    step(1'b1, 1'b0, 0, 1'b0);
    chk("t3.y55", $signed(bus.y), 55);
    slots(L - 1);
    step(1'b1, 1'b0, 0, 1'b0);
    chk("t3.no77", $signed(bus.y), HOLD ? 55 : 0);
    step(1'b0, 1'b0, 0, 1'b1);
    chk("t3.clr_ovr", bus.overrun,  0);
    chk("t3.clr_und", bus.underrun, 0);
    slots(L - 1);

    // 4: underrun, then the next sample appears on the next phase 0
    step(1'b1, 1'b0, 0, 1'b0);
    chk("t4.underrun", bus.underrun, 1);
    slots(L - 1);
    step(1'b0, 1'b1, -131072, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0);
    chk("t4.ymin", $signed(bus.y), -131072);
    slots(L - 1);
    step(1'b0, 1'b0, 0, 1'b1);

    // 5a: sample arrives with empty buffer on the phase-0 strobe
    step(1'b1, 1'b1, 9, 1'b0);
    chk("t5a.underrun", bus.underrun, 1);
    chk("t5a.in_ready", bus.in_ready, 0);
    slots(L - 1);
    step(1'b1, 1'b0, 0, 1'b0);
    chk("t5a.y9", $signed(bus.y), 9);
    step(1'b0, 1'b0, 0, 1'b1);
    // 5b: buffer holds 4 when 9 is offered on the phase-0 strobe
    step(1'b0, 1'b1, 4, 1'b0);
    slots(L - 1);
    step(1'b1, 1'b1, 9, 1'b0);
    chk("t5b.y4",      $signed(bus.y), 4);
    chk("t5b.overrun", bus.overrun,    1);
    slots(L - 1);
    step(1'b1, 1'b0, 0, 1'b0);
    chk("t5b.lost9", $signed(bus.y), HOLD ? 4 : 0);
    chk("t5b.underrun", bus.underrun, 1);

    // 6: asynchronous reset mid-frame at phase 2 with buffer full
    step(1'b0, 1'b0, 0, 1'b1);
    step(1'b0, 1'b1, 5, 1'b0);
    slots(1);
    chk("t6.pre_phase", bus.phase,    2);
    chk("t6.pre_full",  bus.in_ready, 0);
    bus.clk_en    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.clr_flags = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t6.phase",    bus.phase,      0);
    chk("t6.in_ready", bus.in_ready,   1);
    chk("t6.y",        $signed(bus.y), 0);
    chk("t6.overrun",  bus.overrun,    0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
           rnd_sample(), $urandom_range(0, 19) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
